// File: rtl/comma_sync_if.sv
// comma_sync_if: aligner-side bundle for comma_sync
//   pattern_i  expected comma flag pattern of an aligned comma word
//   comma_i    per-byte comma flags from the aligner (byte 0 = LSB)
//   data_i     aligned data from the aligner
//   comma_o    comma_i registered
//   data_o     data_i registered
//   valid_o    data_o/comma_o belong to a locked link
//   synced_o   link is in SYNC
//   err_o      1-cycle pulse per bad comma word
//   slave modport is the comma_sync side, master the upstream/consumer side
interface comma_sync_if #(
  parameter int BYTES = 4
);
  logic [BYTES-1:0]   pattern_i;
  logic [BYTES-1:0]   comma_i;
  logic [BYTES*8-1:0] data_i;
  logic [BYTES-1:0]   comma_o;
  logic [BYTES*8-1:0] data_o;
  logic               valid_o;
  logic               synced_o;
  logic               err_o;
  modport slave (
    input  pattern_i, comma_i, data_i,
    output comma_o, data_o, valid_o, synced_o, err_o
  );
  modport master (
    output pattern_i, comma_i, data_i,
    input  comma_o, data_o, valid_o, synced_o, err_o
  );
endinterface

// File: rtl/comma_sync.sv
// comma_sync: link lock/loss tracking on aligned comma flags with 1-cycle data forwarding
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     comma_sync_if slave: pattern/comma/data in, registered comma/data, valid, synced, err out
module comma_sync #(
  parameter int BYTES    = 4,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int TIMEOUT  = 256
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  comma_sync_if.slave  bus
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(LOSS_CNT + 1);
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {HUNT, ACQ, SYNC} state_t;
  state_t        state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [EW-1:0] err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          good, bad, tmo;
  assign good = (bus.comma_i == bus.pattern_i) && (bus.comma_i != '0);
  assign bad  = (bus.comma_i != '0) && !good;
  assign tmo  = (tmo_q == TW'(TIMEOUT - 1)) && !good;
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = err_q;
    case (state_q)
      HUNT: if (good) begin
        good_d  = GW'(1);
        err_d   = '0;
        state_d = (LOCK_CNT == 1) ? SYNC : ACQ;
      end
      ACQ: if (good) begin
        good_d = good_q + 1'b1;
        if (good_d == GW'(LOCK_CNT)) begin
          state_d = SYNC;
          err_d   = '0;
        end
      end else if (bad || tmo) begin
        state_d = HUNT;
        good_d  = '0;
      end
      SYNC: if (good) begin
        err_d = '0;
      end else if ((bad && (err_q + 1'b1 == EW'(LOSS_CNT))) || tmo) begin
        state_d = HUNT;
        good_d  = '0;
        err_d   = '0;
      end else if (bad) begin
        err_d = err_q + 1'b1;
      end
      default: begin
        state_d = HUNT;
        good_d  = '0;
        err_d   = '0;
      end
    endcase
    // timer idles at zero while hunting and restarts on every good comma
    tmo_d = (state_d == HUNT || good) ? '0 :
            (tmo_q == TW'(TIMEOUT)) ? tmo_q : tmo_q + 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= HUNT;
      good_q       <= '0;
      err_q        <= '0;
      tmo_q        <= '0;
      bus.comma_o  <= '0;
      bus.data_o   <= '0;
      bus.valid_o  <= 1'b0;
      bus.synced_o <= 1'b0;
      bus.err_o    <= 1'b0;
    end else begin
      state_q      <= state_d;
      good_q       <= good_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
      bus.comma_o  <= bus.comma_i;
      bus.data_o   <= bus.data_i;
      bus.valid_o  <= (state_d == SYNC);
      bus.synced_o <= (state_d == SYNC);
      bus.err_o    <= bad;
    end
  end
endmodule

// File: tb/tb_comma_sync.sv
// tb_comma_sync: directed checks of lock, abort, loss, error reset, timeout and async reset
module tb_comma_sync;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int evals = 0;
  int fails = 0;
  int seq = 0;
  always #5 clk_i = ~clk_i;
  comma_sync_if #(.BYTES(4)) bus ();
  comma_sync #(.BYTES(4), .LOCK_CNT(4), .LOSS_CNT(3), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evals++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " data_o"}, bus.data_o, 32'h0);
    chk({tag, " comma_o"}, {28'h0, bus.comma_o}, 32'h0);
    chk({tag, " valid_o"}, {31'h0, bus.valid_o}, 32'h0);
    chk({tag, " synced_o"}, {31'h0, bus.synced_o}, 32'h0);
    chk({tag, " err_o"}, {31'h0, bus.err_o}, 32'h0);
  endtask
  task automatic step(input logic [3:0] c, input logic es, input logic ee, input string tag);
    logic [31:0] d;
    d = 32'hC0DE_0000 + 32'(seq);
    seq++;
    @(negedge clk_i);
    bus.comma_i = c;
    bus.data_i  = d;
    @(posedge clk_i);
    #1;
    chk({tag, " data_o"}, bus.data_o, d);
    chk({tag, " comma_o"}, {28'h0, bus.comma_o}, {28'h0, c});
    chk({tag, " synced_o"}, {31'h0, bus.synced_o}, {31'h0, es});
    chk({tag, " valid_o"}, {31'h0, bus.valid_o}, {31'h0, es});
    chk({tag, " err_o"}, {31'h0, bus.err_o}, {31'h0, ee});
  endtask
  task automatic reset_dut();
    @(negedge clk_i);
    rst_ni = 1'b0;
    bus.comma_i = '0;
    bus.data_i  = '0;
    #1;
    chk_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask
  initial begin
    bus.pattern_i = 4'b0001;
    bus.comma_i   = '0;
    bus.data_i    = '0;
    #2;
    chk_zero("por");
    reset_dut();
    // 1. lock with a good comma every 4th word
    for (int g = 1; g <= 6; g++) begin
      step(4'b0001, g >= 4, 1'b0, "lock_good");
      for (int i = 0; i < 3; i++) step(4'b0000, g >= 4, 1'b0, "lock_none");
    end
    // 2. acquisition abort by a misplaced comma
    reset_dut();
    step(4'b0001, 1'b0, 1'b0, "abort_g1");
    step(4'b0000, 1'b0, 1'b0, "abort_n");
    step(4'b0001, 1'b0, 1'b0, "abort_g2");
    step(4'b0100, 1'b0, 1'b1, "abort_bad");
    step(4'b0000, 1'b0, 1'b0, "abort_after");
    step(4'b0001, 1'b0, 1'b0, "relock_g1");
    step(4'b0001, 1'b0, 1'b0, "relock_g2");
    step(4'b0001, 1'b0, 1'b0, "relock_g3");
    step(4'b0001, 1'b1, 1'b0, "relock_g4");
    // 3. loss after three bad commas separated by none words
    step(4'b0010, 1'b1, 1'b1, "loss_b1");
    step(4'b0000, 1'b1, 1'b0, "loss_n1");
    step(4'b0010, 1'b1, 1'b1, "loss_b2");
    step(4'b0000, 1'b1, 1'b0, "loss_n2");
    step(4'b0010, 1'b0, 1'b1, "loss_b3");
    step(4'b0000, 1'b0, 1'b0, "loss_n3");
    // 4. a good comma clears the error count
    for (int g = 1; g <= 4; g++) begin
      step(4'b0001, g == 4, 1'b0, "errrst_lock");
      step(4'b0000, g == 4, 1'b0, "errrst_gap");
    end
    step(4'b0010, 1'b1, 1'b1, "errrst_b1");
    step(4'b0010, 1'b1, 1'b1, "errrst_b2");
    step(4'b0001, 1'b1, 1'b0, "errrst_g");
    step(4'b0010, 1'b1, 1'b1, "errrst_b3");
    step(4'b0010, 1'b1, 1'b1, "errrst_b4");
    step(4'b0001, 1'b1, 1'b0, "errrst_g2");
    // 5. starvation timeout, then a good on the last cycle keeps lock
    for (int i = 0; i < 15; i++) step(4'b0000, 1'b1, 1'b0, "tmo_hold");
    step(4'b0000, 1'b0, 1'b0, "tmo_drop");
    for (int g = 1; g <= 4; g++) step(4'b0001, g == 4, 1'b0, "tmo_relock");
    for (int i = 0; i < 15; i++) step(4'b0000, 1'b1, 1'b0, "tmo_hold2");
    step(4'b0001, 1'b1, 1'b0, "tmo_save");
    step(4'b0000, 1'b1, 1'b0, "tmo_after");
    // pattern change takes effect on the next word
    bus.pattern_i = 4'b0010;
    step(4'b0001, 1'b1, 1'b1, "pat_old_bad");
    step(4'b0010, 1'b1, 1'b0, "pat_new_good");
    bus.pattern_i = 4'b0001;
    step(4'b0001, 1'b1, 1'b0, "pat_back");
    // 6. async reset between edges while locked
    step(4'b0100, 1'b1, 1'b1, "arst_pre");
    #2;
    rst_ni = 1'b0;
    #1;
    chk_zero("arst");
    @(negedge clk_i);
    bus.comma_i = '0;
    bus.data_i  = '0;
    @(posedge clk_i);
    #1;
    chk_zero("arst_hold");
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(4'b0001, 1'b0, 1'b0, "arst_g1");
    step(4'b0001, 1'b0, 1'b0, "arst_g2");
    step(4'b0001, 1'b0, 1'b0, "arst_g3");
    step(4'b0001, 1'b1, 1'b0, "arst_g4");
    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end
endmodule
